// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single DataMemory port: IDLE -> ACCESS -> DONE per access.
// Define DMEM_ARB_RR_EN for round-robin conflicts; default is fixed priority with anti-starvation.
module dmem_arbiter #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0,
  input  logic                      wr0,
  input  logic [DATA_BIT_WIDTH-1:0] addr0,
  input  logic [DATA_BIT_WIDTH-1:0] wdata0,
  output logic                      ack0,
  output logic [DATA_BIT_WIDTH-1:0] rdata0,
  input  logic                      req1,
  input  logic                      wr1,
  input  logic [DATA_BIT_WIDTH-1:0] addr1,
  input  logic [DATA_BIT_WIDTH-1:0] wdata1,
  output logic                      ack1,
  output logic [DATA_BIT_WIDTH-1:0] rdata1,
  output logic                      mem_wr,
  output logic [DATA_BIT_WIDTH-1:0] mem_addr,
  output logic [DATA_BIT_WIDTH-1:0] mem_din,
  input  logic [DATA_BIT_WIDTH-1:0] mem_dout,
  output logic                      busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                    state, state_next;
  logic                      gnt_q;
  logic                      wr_q;
  logic [DATA_BIT_WIDTH-1:0] addr_q;
  logic [DATA_BIT_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]          starve_cnt, starve_next;
  logic                      last_grant;
  logic                      grant_vld;
  logic                      grant_id;

  // Arbitration: evaluated every cycle, only acted on in IDLE
  always_comb begin
    grant_vld   = req0 | req1;
    grant_id    = 1'b0;
    starve_next = starve_cnt;
`ifdef DMEM_ARB_RR_EN
    starve_next = '0;
    if (req0 && req1)
      grant_id = ~last_grant;
    else
      grant_id = req1;
`else
    if (req0 && req1) begin
      if (starve_cnt == CNT_W'(STARVE_LIMIT)) begin
        grant_id    = 1'b1;
        starve_next = '0;
      end else begin
        starve_next = starve_cnt + 1'b1;
      end
    end else if (req1) begin
      grant_id    = 1'b1;
      starve_next = '0;
    end
`endif
  end

`ifdef DMEM_ARB_RR_EN
  logic unused_starve_cnt;
  assign unused_starve_cnt = ^starve_cnt;
`else
  // last_grant is tracked for observability but does not steer fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_vld) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state, acks and per-port read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_next;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      if (state == IDLE && grant_vld) begin
        gnt_q      <= grant_id;
        wr_q       <= grant_id ? wr1 : wr0;
        starve_cnt <= starve_next;
        last_grant <= grant_id;
      end
      if (state == ACCESS) begin
        if (gnt_q) ack1 <= 1'b1;
        else       ack0 <= 1'b1;
        if (!wr_q) begin
          if (gnt_q) rdata1 <= mem_dout;
          else       rdata0 <= mem_dout;
        end
      end
    end
  end

  // Latched request payload; holds between accesses so mem_addr/mem_din stay stable
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      addr_q  <= grant_id ? addr1  : addr0;
      wdata_q <= grant_id ? wdata1 : wdata0;
    end
  end

  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign mem_wr   = (state == ACCESS) & wr_q & ~reset;
  assign busy     = (state != IDLE);

endmodule
